snake_engine: RTL and testbench

Parametrised successor of the 16x16 snake game core. Grid size, maximum snake length, wall mode and RNG seed are generic.
- Snake body is a circular position buffer plus an incremental occupancy bitmap, so rendering and collision lookups are single-cycle.
- Food is placed by an LFSR rejection search that never lands on the body.
- Sits between the IR direction decoder and the LED-matrix driver; advances one move per game_clk-domain step pulse.

---
 rtl/snake_pkg.sv | 35 +++
 rtl/snake_lfsr.sv | 33 +++
 rtl/snake_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_snake_engine.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game core and its neighbours.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_FOOD = 2'd1,
        ST_OVER = 2'd2,
        ST_WIN  = 2'd3
    } state_t;

    // NEC codes the upstream IR decoder maps onto dir_t.
    localparam logic [31:0] IR_UP    = 32'h20DF6A95;
    localparam logic [31:0] IR_DOWN  = 32'h20DFEA15;
    localparam logic [31:0] IR_LEFT  = 32'h20DF1AE5;
    localparam logic [31:0] IR_RIGHT = 32'h20DF9A65;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 16-bit Galois LFSR used as the food-placement random source.
module snake_lfsr
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        game_clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/snake_engine.sv
// Snake game core: circular body buffer, occupancy bitmap, LFSR food search.
// step is a fire-and-forget pulse: it is consumed only while busy=0 and no
// terminal flag is set; otherwise it is silently dropped.
module snake_engine
    import snake_pkg::*;
#(
    parameter int          GRID_W    = 16,
    parameter int          GRID_H    = 16,
    parameter int          MAX_LEN   = 64,
    parameter int          WRAP      = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          FOOD_INIT = 138,
    localparam int         CELLS     = GRID_W * GRID_H,
    localparam int         POS_W     = $clog2(CELLS),
    localparam int         LEN_W     = $clog2(MAX_LEN + 1)
) (
    input  logic             game_clk,
    input  logic             reset_n,
    input  logic             step,
    input  logic             dir_valid,
    input  logic [1:0]       dir,
    output logic [CELLS-1:0] grid,
    output logic [POS_W-1:0] head_pos,
    output logic [POS_W-1:0] food_pos,
    output logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             game_over,
    output logic             win,
    output state_t           dbg_state
);

    localparam int COL_W     = $clog2(GRID_W);
    localparam int ROW_W     = $clog2(GRID_H);
    localparam int IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int ROW_INIT  = GRID_H / 2;
    localparam int COL_INIT  = GRID_W / 2;
    localparam int HEAD_INIT = ROW_INIT * GRID_W + COL_INIT;
    localparam logic [CELLS-1:0] ONE = {{(CELLS-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [POS_W-1:0]  head_q, head_d;
    logic [POS_W-1:0]  food_q, food_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  hidx_q, hidx_d;
    logic [IDX_W-1:0]  tidx_q, tidx_d;
    logic [CELLS-1:0]  occ_q, occ_d;
    dir_t              cur_q, cur_d;
    dir_t              pend_q, pend_d;
    logic [POS_W-1:0]  body_q [MAX_LEN];
    logic              push;

    logic [ROW_W-1:0]  nxt_row;
    logic [COL_W-1:0]  nxt_col;
    logic              off_grid;
    logic [POS_W-1:0]  nxt_pos;
    logic [POS_W-1:0]  tail_pos;
    logic              eat;
    logic              hit_self;
    logic [15:0]       lfsr_q;
    logic [POS_W-1:0]  cand;
    logic              cand_ok;
    logic              unused_lfsr;

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(MAX_LEN - 1)) ? '0 : i + IDX_W'(1);
    endfunction

    snake_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .game_clk (game_clk),
        .reset_n  (reset_n),
        .en       (1'b1),
        .q        (lfsr_q)
    );

    // Next head cell; on a wall with WRAP=0 the coordinates are don't-care.
    always_comb begin
        nxt_row  = row_q;
        nxt_col  = col_q;
        off_grid = 1'b0;
        case (pend_q)
            DIR_UP: begin
                if (row_q == '0) begin
                    off_grid = (WRAP == 0);
                    nxt_row  = ROW_W'(GRID_H - 1);
                end else begin
                    nxt_row = row_q - ROW_W'(1);
                end
            end
            DIR_DOWN: begin
                if (row_q == ROW_W'(GRID_H - 1)) begin
                    off_grid = (WRAP == 0);
                    nxt_row  = '0;
                end else begin
                    nxt_row = row_q + ROW_W'(1);
                end
            end
            DIR_LEFT: begin
                if (col_q == '0) begin
                    off_grid = (WRAP == 0);
                    nxt_col  = COL_W'(GRID_W - 1);
                end else begin
                    nxt_col = col_q - COL_W'(1);
                end
            end
            default: begin
                if (col_q == COL_W'(GRID_W - 1)) begin
                    off_grid = (WRAP == 0);
                    nxt_col  = '0;
                end else begin
                    nxt_col = col_q + COL_W'(1);
                end
            end
        endcase
    end

    assign nxt_pos     = POS_W'(32'(nxt_row) * GRID_W + 32'(nxt_col));
    assign tail_pos    = body_q[tidx_q];
    assign eat         = (nxt_pos == food_q);
    // The tail cell is free to enter unless eating keeps the tail in place.
    assign hit_self    = occ_q[nxt_pos] && !((nxt_pos == tail_pos) && !eat);
    assign cand        = lfsr_q[POS_W-1:0];
    assign cand_ok     = (32'(cand) < CELLS) && !occ_q[cand];
    assign unused_lfsr = ^lfsr_q[15:POS_W];

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        head_d  = head_q;
        food_d  = food_q;
        len_d   = len_q;
        hidx_d  = hidx_q;
        tidx_d  = tidx_q;
        occ_d   = occ_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        push    = 1'b0;

        if ((state_q == ST_RUN || state_q == ST_FOOD) && dir_valid &&
            !(len_q > LEN_W'(1) && dir_t'(dir) == opposite(cur_q))) begin
            pend_d = dir_t'(dir);
        end

        case (state_q)
            ST_RUN: begin
                if (step) begin
                    if (off_grid || hit_self) begin
                        state_d = ST_OVER;
                    end else begin
                        push   = 1'b1;
                        hidx_d = inc_idx(hidx_q);
                        row_d  = nxt_row;
                        col_d  = nxt_col;
                        head_d = nxt_pos;
                        cur_d  = pend_q;
                        if (!eat) begin
                            occ_d[tail_pos] = 1'b0;
                            tidx_d          = inc_idx(tidx_q);
                        end
                        occ_d[nxt_pos] = 1'b1;
                        if (eat) begin
                            len_d   = len_q + LEN_W'(1);
                            state_d = (len_q == LEN_W'(MAX_LEN - 1)) ? ST_WIN : ST_FOOD;
                        end
                    end
                end
            end
            ST_FOOD: begin
                if (cand_ok) begin
                    food_d  = cand;
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
            row_q   <= ROW_W'(ROW_INIT);
            col_q   <= COL_W'(COL_INIT);
            head_q  <= POS_W'(HEAD_INIT);
            food_q  <= POS_W'(FOOD_INIT);
            len_q   <= LEN_W'(1);
            hidx_q  <= '0;
            tidx_q  <= '0;
            occ_q   <= ONE << HEAD_INIT;
            cur_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            head_q  <= head_d;
            food_q  <= food_d;
            len_q   <= len_d;
            hidx_q  <= hidx_d;
            tidx_q  <= tidx_d;
            occ_q   <= occ_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
        end
    end

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            body_q[0] <= POS_W'(HEAD_INIT);
        end else if (push) begin
            body_q[hidx_d] <= nxt_pos;
        end
    end

    assign grid      = occ_q | (ONE << food_q);
    assign head_pos  = head_q;
    assign food_pos  = food_q;
    assign length    = len_q;
    assign busy      = (state_q == ST_FOOD);
    assign game_over = (state_q == ST_OVER);
    assign win       = (state_q == ST_WIN);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: three configurations driven one at a time against a
// queue-based game model (body as a position list, rows/cols by div/mod).
module tb_snake_engine;
    import snake_pkg::*;

    logic       game_clk = 1'b0;
    logic       reset_n  = 1'b0;
    logic       step     = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir      = 2'd0;
    int         sel      = 0;

    always #5 game_clk = ~game_clk;

    logic [255:0] g0, g1;
    logic [15:0]  g2;
    logic [7:0]   hp0, hp1, fp0, fp1;
    logic [3:0]   hp2, fp2;
    logic [6:0]   ln0, ln1;
    logic [2:0]   ln2;
    logic         b0, b1, b2, ov0, ov1, ov2, w0, w1, w2;
    state_t       st0, st1, st2;

    snake_engine u0 (
        .game_clk(game_clk), .reset_n(reset_n), .step(step && sel == 0),
        .dir_valid(dir_valid && sel == 0), .dir(dir), .grid(g0), .head_pos(hp0),
        .food_pos(fp0), .length(ln0), .busy(b0), .game_over(ov0), .win(w0), .dbg_state(st0)
    );

    snake_engine #(.WRAP(1)) u1 (
        .game_clk(game_clk), .reset_n(reset_n), .step(step && sel == 1),
        .dir_valid(dir_valid && sel == 1), .dir(dir), .grid(g1), .head_pos(hp1),
        .food_pos(fp1), .length(ln1), .busy(b1), .game_over(ov1), .win(w1), .dbg_state(st1)
    );

    snake_engine #(.GRID_W(4), .GRID_H(4), .MAX_LEN(5), .WRAP(0), .FOOD_INIT(11)) u2 (
        .game_clk(game_clk), .reset_n(reset_n), .step(step && sel == 2),
        .dir_valid(dir_valid && sel == 2), .dir(dir), .grid(g2), .head_pos(hp2),
        .food_pos(fp2), .length(ln2), .busy(b2), .game_over(ov2), .win(w2), .dbg_state(st2)
    );

    logic [255:0] o_grid;
    logic [7:0]   o_head, o_food;
    logic [6:0]   o_len;
    logic         o_busy, o_over, o_win;
    logic [1:0]   o_st;

    always_comb begin
        o_grid = '0; o_head = '0; o_food = '0; o_len = '0;
        o_busy = 1'b0; o_over = 1'b0; o_win = 1'b0; o_st = '0;
        case (sel)
            0: begin
                o_grid = g0; o_head = hp0; o_food = fp0; o_len = ln0;
                o_busy = b0; o_over = ov0; o_win = w0; o_st = st0;
            end
            1: begin
                o_grid = g1; o_head = hp1; o_food = fp1; o_len = ln1;
                o_busy = b1; o_over = ov1; o_win = w1; o_st = st1;
            end
            default: begin
                o_grid = 256'(g2); o_head = 8'(hp2); o_food = 8'(fp2); o_len = 7'(ln2);
                o_busy = b2; o_over = ov2; o_win = w2; o_st = st2;
            end
        endcase
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Game state codes: 0 running, 1 placing food, 2 game over, 3 won.
    int cfg_w, cfg_h, cfg_max, cfg_wrap, cfg_food;
    int m_body[$];          // m_body[0] is the tail, m_body[$] the head
    int m_food, m_state, m_cur, m_pend;
    logic [15:0] m_lfsr;

    function automatic int opp(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit in_body(input int p);
        foreach (m_body[i]) if (m_body[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    // Cell reached from p moving d; -1 when it leaves a walled grid.
    function automatic int next_cell(input int p, input int d);
        int r = p / cfg_w;
        int c = p % cfg_w;
        case (d)
            0: r = r - 1;
            1: r = r + 1;
            2: c = c - 1;
            default: c = c + 1;
        endcase
        if (r < 0 || r >= cfg_h || c < 0 || c >= cfg_w) begin
            if (cfg_wrap == 0) return -1;
            r = (r + cfg_h) % cfg_h;
            c = (c + cfg_w) % cfg_w;
        end
        return r * cfg_w + c;
    endfunction

    task automatic select_dut(input int k);
        sel = k;
        if (k == 2) begin
            cfg_w = 4; cfg_h = 4; cfg_max = 5; cfg_wrap = 0; cfg_food = 11;
        end else begin
            cfg_w = 16; cfg_h = 16; cfg_max = 64; cfg_wrap = (k == 1) ? 1 : 0; cfg_food = 138;
        end
    endtask

    task automatic model_reset();
        m_body = {};
        m_body.push_back((cfg_h / 2) * cfg_w + cfg_w / 2);
        m_food  = cfg_food;
        m_state = 0;
        m_cur   = 3;
        m_pend  = 3;
        m_lfsr  = 16'hACE1;
    endtask

    // Applies the inputs of one clock edge to the model.
    task automatic model_edge(input bit s, input bit dv, input int d);
        int old_len   = m_body.size();
        int old_cur   = m_cur;
        int old_state = m_state;
        int nxt, cand;
        bit eat;
        if (m_state == 0 && s) begin
            nxt = next_cell(m_body[$], m_pend);
            eat = (nxt == m_food);
            if (nxt < 0) m_state = 2;
            else if (in_body(nxt) && !(nxt == m_body[0] && !eat)) m_state = 2;
            else begin
                m_body.push_back(nxt);
                if (!eat) void'(m_body.pop_front());
                m_cur = m_pend;
                if (eat) m_state = (m_body.size() == cfg_max) ? 3 : 1;
            end
        end else if (m_state == 1) begin
            cand = int'(m_lfsr) % (1 << $clog2(cfg_w * cfg_h));
            if (cand < cfg_w * cfg_h && !in_body(cand)) begin
                m_food  = cand;
                m_state = 0;
            end
        end
        if (dv && old_state < 2 && !(old_len > 1 && d == opp(old_cur))) m_pend = d;
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic check_all();
        logic [255:0] eg = '0;
        foreach (m_body[i]) eg[m_body[i]] = 1'b1;
        eg[m_food] = 1'b1;
        check("head", 256'(o_head), 256'(m_body[$]));
        check("food", 256'(o_food), 256'(m_food));
        check("length", 256'(o_len), 256'(m_body.size()));
        check("grid", o_grid, eg);
        check("busy", 256'(o_busy), 256'(m_state == 1));
        check("game_over", 256'(o_over), 256'(m_state == 2));
        check("win", 256'(o_win), 256'(m_state == 3));
        check("state", 256'(o_st), 256'(m_state));
    endtask

    // ---------------- drivers ----------------
    task automatic cycle(input logic s, input logic dv, input logic [1:0] d);
        step = s; dir_valid = dv; dir = d;
        model_edge(s, dv, int'(d));
        @(posedge game_clk);
        #1;
        step = 1'b0; dir_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; step = 1'b0; dir_valid = 1'b0;
        @(posedge game_clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (o_busy && n < budget) begin
            cycle(1'b0, 1'b0, 2'd0);
            check_all();
            n++;
        end
        if (o_busy) check("busy_timeout", 256'(o_busy), 256'(0));
    endtask

    function automatic int greedy_dir();
        int best = -1;
        int best_d = $urandom_range(0, 3);
        int head = m_body[$];
        int n, dr, dc, score;
        for (int d = 0; d < 4; d++) begin
            if (m_body.size() > 1 && d == opp(m_cur)) continue;
            n = next_cell(head, d);
            if (n < 0) continue;
            if (in_body(n) && !(n == m_body[0] && n != m_food)) continue;
            dr = n / cfg_w - m_food / cfg_w;
            dc = n % cfg_w - m_food % cfg_w;
            score = ((dr < 0 ? -dr : dr) + (dc < 0 ? -dc : dc)) * 4 + $urandom_range(0, 3);
            if (best < 0 || score < best) begin
                best = score;
                best_d = d;
            end
        end
        return best_d;
    endfunction

    task automatic walk_right(input int k, input int final_head, input bit exp_over);
        select_dut(k);
        do_reset();
        exp_q = {};
        for (int i = 1; i <= 7; i++) exp_q.push_back(8'(136 + i));
        exp_q.push_back(8'(final_head));
        for (int i = 1; i <= 8; i++) begin
            wait_idle(300);
            cycle(1'b1, 1'b0, 2'd0);
            check_all();
            check("walk_head", 256'(o_head), 256'(exp_q.pop_front()));
        end
        check("walk_over", 256'(o_over), 256'(exp_over));
        if (exp_over) begin
            for (int i = 0; i < 3; i++) begin
                cycle(1'b1, 1'b1, 2'(i));
                check_all();
                check("frozen_head", 256'(o_head), 256'(final_head));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] rst_grid;
        bit saw_win;

        select_dut(0);
        do_reset();
        rst_grid = '0;
        rst_grid[136] = 1'b1;
        rst_grid[138] = 1'b1;
        check_all();
        check("rst_head", 256'(o_head), 256'(136));
        check("rst_food", 256'(o_food), 256'(138));
        check("rst_len", 256'(o_len), 256'(1));
        check("rst_grid", o_grid, rst_grid);

        cycle(1'b1, 1'b0, 2'd0);
        check_all();
        check("s1_head", 256'(o_head), 256'(137));
        check("s1_bit136", 256'(o_grid[136]), 256'(0));
        cycle(1'b1, 1'b0, 2'd0);
        check_all();
        check("s2_head", 256'(o_head), 256'(138));
        check("s2_len", 256'(o_len), 256'(2));
        check("s2_busy", 256'(o_busy), 256'(1));
        wait_idle(300);
        check("food_off_body", 256'(o_food == 8'd137 || o_food == 8'd138), 256'(0));

        walk_right(0, 143, 1'b1);
        walk_right(1, 128, 1'b0);

        select_dut(0);
        do_reset();
        cycle(1'b0, 1'b1, 2'd2);
        cycle(1'b1, 1'b0, 2'd0);
        check_all();
        check("len1_left", 256'(o_head), 256'(135));
        do_reset();
        cycle(1'b1, 1'b0, 2'd0);
        cycle(1'b1, 1'b0, 2'd0);
        wait_idle(300);
        cycle(1'b0, 1'b1, 2'd2);
        cycle(1'b1, 1'b0, 2'd0);
        check_all();
        check("reverse_dropped", 256'(o_head), 256'(139));

        saw_win = 1'b0;
        for (int g = 0; g < 30 && !saw_win; g++) begin
            select_dut(2);
            do_reset();
            repeat ($urandom_range(0, 7)) begin
                cycle(1'b0, 1'b0, 2'd0);
                check_all();
            end
            for (int mv = 0; mv < 80 && m_state < 2; mv++) begin
                wait_idle(100);
                cycle(1'b0, 1'b1, 2'(greedy_dir()));
                cycle(1'b1, 1'b0, 2'd0);
                check_all();
            end
            if (o_win) begin
                saw_win = 1'b1;
                check("win_len", 256'(o_len), 256'(5));
                cycle(1'b1, 1'b1, 2'd0);
                check_all();
            end
        end
        check("win_seen", 256'(saw_win), 256'(1));

        for (int g = 0; g < 40; g++) begin
            select_dut((g % 4 == 3) ? int'($urandom_range(0, 1)) : 2);
            do_reset();
            for (int c = 0; c < 120; c++) begin
                cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                      2'($urandom_range(0, 1) ? greedy_dir() : int'($urandom_range(0, 3))));
                check_all();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
